meta_pair_rx: RTL and testbench
===============================

META_PAIR_RX -- requirements
Module: meta_pair_rx

Interface
REQ-001 Parameter DW, default 128, metadata word width in bits.
REQ-002 Parameter CW, default 32, pair-counter width in bits.
REQ-003 clk  input  1  single clock, all logic on rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 axis_meta1_tdata  input  DW  metadata word, stream 1.
REQ-006 axis_meta1_tvalid  input  1  stream 1 word valid.
REQ-007 axis_meta1_tready  output  1  stream 1 accept.
REQ-008 axis_meta2_tdata / axis_meta2_tvalid / axis_meta2_tready: same as REQ-005..007, stream 2.
REQ-009 axis_pair_tdata  output  DW  paired metadata word (stream 1 value).
REQ-010 axis_pair_tvalid  output  1  pair available.
REQ-011 axis_pair_tready  input  1  downstream accept.
REQ-012 axis_pair_tuser  output  1  mismatch flag for the presented pair.
REQ-013 pair_count  output  CW  number of pairs delivered downstream.
REQ-014 mismatch_count  output  16  number of mismatching pairs delivered.

Function
REQ-015 Each stream has a one-entry slot; a beat is accepted when tvalid && tready.
REQ-016 axis_metaK_tready = NOT slotK_full (registered flag only, no combinational path from any input).
REQ-017 FSM states: EMPTY, GOT1, GOT2, PAIR; state PAIR equals axis_pair_tvalid = 1.
REQ-018 EMPTY -> GOT1 on stream-1 accept only; -> GOT2 on stream-2 accept only; -> PAIR on both accepted in the same cycle.
REQ-019 GOT1 -> PAIR on stream-2 accept; GOT2 -> PAIR on stream-1 accept; otherwise hold.
REQ-020 PAIR -> EMPTY on axis_pair_tvalid && axis_pair_tready; both slots freed in that cycle; no new beat is accepted in that cycle.
REQ-021 Latency: pair valid on the cycle after the second beat is accepted; maximum throughput one pair per 2 cycles.
REQ-022 axis_pair_tdata, axis_pair_tuser held stable while tvalid=1 and tready=0.
REQ-023 Ordering: the Nth beat of stream 1 is always paired with the Nth beat of stream 2; a stream never overtakes by more than one beat.
REQ-024 pair_count increments by 1 per downstream handshake; wraps modulo 2^CW.
REQ-025 mismatch_count increments per downstream handshake with tuser=1; saturates at 0xFFFF.

Reset
REQ-026 While resetn=0: state EMPTY, both slots empty, all tready=0 during reset then 1 on first cycle after release, axis_pair_tvalid=0, tdata=0, tuser=0, pair_count=0, mismatch_count=0.
REQ-027 Reset asserted mid-operation discards any captured beats and an undelivered pair immediately, without waiting for a clock edge.

Configuration
REQ-028 Macro META_PAIR_CHECK_EN defined: tuser = (slot1 data != slot2 data), computed when entering PAIR, and mismatch_count active.
REQ-029 Macro absent: tuser tied 0, mismatch_count tied 0, comparator and slot-2 data storage not synthesised (stream 2 still handshakes).

Structure
REQ-030 Package meta_pkg holds DW default, CW default, mismatch counter width (16) and the FSM state enum.
REQ-031 Sub-module meta_slot (one-entry capture register with full flag, load, clear) instantiated once per stream.

Verification
REQ-032 Both streams present 1638 continuously, tready=1 -> pair tdata=1638, tuser=0, one pair every 2 cycles, pair_count 10 after 20 cycles.
REQ-033 Stream 1 sends 5, stream 2 idle for 7 cycles then sends 5 -> meta1 tready=0 for those cycles, pair appears 1 cycle after stream-2 accept.
REQ-034 Stream 1=1638, stream 2=1639, check enabled -> tuser=1, mismatch_count=1; macro absent -> tuser=0, mismatch_count=0.
REQ-035 Pair held with axis_pair_tready=0 for 10 cycles, inputs change -> tdata/tuser stable, both input tready=0, pair_count unchanged.
REQ-036 resetn pulsed low while in GOT1 -> tvalid/tready/counters at reset values asynchronously; next pair formed only from post-reset beats.
REQ-037 Force mismatch_count to 0xFFFF, deliver one more mismatching pair -> stays 0xFFFF; pair_count at 2^CW-1 plus one pair -> 0.

Source files
------------

// File: rtl/meta_pkg.sv
// -----------------------------------------------------------------------------
// meta_pkg
// Shared definitions for the metadata pair receiver:
//   DW_DEF   default metadata word width
//   CW_DEF   default pair-counter width
//   MCW      mismatch counter width (saturating)
//   pair_state_e  pairing FSM states
// Optional feature macro used by the receiver: META_PAIR_CHECK_EN
// -----------------------------------------------------------------------------
package meta_pkg;
   localparam int DW_DEF = 128;
   localparam int CW_DEF = 32;
   localparam int MCW    = 16;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_GOT1  = 2'd1,
      ST_GOT2  = 2'd2,
      ST_PAIR  = 2'd3
   } pair_state_e;
endpackage

// File: rtl/meta_slot.sv
// -----------------------------------------------------------------------------
// meta_slot
// One-entry capture register with a full flag.
// Ports:
//   clk, resetn      clock, asynchronous active-low reset
//   load             capture din and mark full
//   clear            mark empty (never asserted together with load)
//   din   [DW]       data to capture
//   full             slot holds a beat
//   dout  [DW]       captured data (zero when STORE = 0)
// STORE = 0 keeps only the full flag; no data register is built.
// -----------------------------------------------------------------------------
module meta_slot #(
   parameter int DW    = 128,
   parameter bit STORE = 1'b1
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          load,
   input  logic          clear,
   input  logic [DW-1:0] din,
   output logic          full,
   output logic [DW-1:0] dout
);
   logic full_q, full_d;

   always_comb begin
      full_d = full_q;
      if (load)
         full_d = 1'b1;
      else if (clear)
         full_d = 1'b0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         full_q <= 1'b0;
      else
         full_q <= full_d;
   end

   assign full = full_q;

   generate
      if (STORE) begin : g_store
         logic [DW-1:0] data_q, data_d;

         always_comb begin
            data_d = data_q;
            if (load)
               data_d = din;
         end

         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn)
               data_q <= '0;
            else
               data_q <= data_d;
         end

         assign dout = data_q;
      end else begin : g_nostore
         // Data is intentionally dropped; only the handshake state is kept.
         logic unused_din;
         assign unused_din = ^din;
         assign dout       = '0;
      end
   endgenerate
endmodule

// File: rtl/meta_pair_rx.sv
// -----------------------------------------------------------------------------
// meta_pair_rx
// Pairs one beat from metadata stream 1 with one beat from stream 2 and
// presents the stream-1 word downstream, optionally flagging a mismatch.
// Ports:
//   clk, resetn                       clock, asynchronous active-low reset
//   axis_meta1_tdata/tvalid/tready    stream 1 input
//   axis_meta2_tdata/tvalid/tready    stream 2 input
//   axis_pair_tdata/tvalid/tready     paired output (stream-1 value)
//   axis_pair_tuser                   mismatch flag for the presented pair
//   pair_count      [CW]              pairs delivered (wrapping)
//   mismatch_count  [16]              mismatching pairs delivered (saturating)
// Macro META_PAIR_CHECK_EN: enables the comparator, slot-2 data storage,
// tuser and mismatch_count. Without it tuser and mismatch_count are 0.
// -----------------------------------------------------------------------------
module meta_pair_rx
   import meta_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int CW = CW_DEF
) (
   input  logic           clk,
   input  logic           resetn,
   input  logic [DW-1:0]  axis_meta1_tdata,
   input  logic           axis_meta1_tvalid,
   output logic           axis_meta1_tready,
   input  logic [DW-1:0]  axis_meta2_tdata,
   input  logic           axis_meta2_tvalid,
   output logic           axis_meta2_tready,
   output logic [DW-1:0]  axis_pair_tdata,
   output logic           axis_pair_tvalid,
   input  logic           axis_pair_tready,
   output logic           axis_pair_tuser,
   output logic [CW-1:0]  pair_count,
   output logic [MCW-1:0] mismatch_count
);
`ifdef META_PAIR_CHECK_EN
   localparam bit CHECK = 1'b1;
`else
   localparam bit CHECK = 1'b0;
`endif

   pair_state_e   state_q, state_d;
   logic          rdy_q;
   logic [DW-1:0] pair_tdata_q, pair_tdata_d;
   logic [CW-1:0] pair_cnt_q, pair_cnt_d;
   logic          slot1_full, slot2_full;
   logic [DW-1:0] slot1_data, slot2_data;
   logic          acc1, acc2, hs, enter_pair;
   logic [DW-1:0] word1;

   // rdy_q holds tready low during reset and for the release edge itself.
   assign axis_meta1_tready = rdy_q & ~slot1_full;
   assign axis_meta2_tready = rdy_q & ~slot2_full;

   assign acc1 = axis_meta1_tvalid & axis_meta1_tready;
   assign acc2 = axis_meta2_tvalid & axis_meta2_tready;
   assign hs   = (state_q == ST_PAIR) & axis_pair_tready;

   // A beat accepted this cycle has not reached its slot yet; take it directly.
   assign word1 = acc1 ? axis_meta1_tdata : slot1_data;

   meta_slot #(.DW(DW), .STORE(1'b1)) u_slot1 (
      .clk    (clk),
      .resetn (resetn),
      .load   (acc1),
      .clear  (hs),
      .din    (axis_meta1_tdata),
      .full   (slot1_full),
      .dout   (slot1_data)
   );

   meta_slot #(.DW(DW), .STORE(CHECK)) u_slot2 (
      .clk    (clk),
      .resetn (resetn),
      .load   (acc2),
      .clear  (hs),
      .din    (axis_meta2_tdata),
      .full   (slot2_full),
      .dout   (slot2_data)
   );

   always_comb begin
      state_d      = state_q;
      enter_pair   = 1'b0;
      pair_tdata_d = pair_tdata_q;
      pair_cnt_d   = pair_cnt_q;
      case (state_q)
         ST_EMPTY: begin
            if (acc1 && acc2) enter_pair = 1'b1;
            else if (acc1)    state_d    = ST_GOT1;
            else if (acc2)    state_d    = ST_GOT2;
         end
         ST_GOT1:  if (acc2) enter_pair = 1'b1;
         ST_GOT2:  if (acc1) enter_pair = 1'b1;
         ST_PAIR:  if (hs)   state_d    = ST_EMPTY;
         default:  state_d = ST_EMPTY;
      endcase
      if (enter_pair) begin
         state_d      = ST_PAIR;
         pair_tdata_d = word1;
      end
      if (hs)
         pair_cnt_d = pair_cnt_q + CW'(1);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= ST_EMPTY;
         rdy_q        <= 1'b0;
         pair_tdata_q <= '0;
         pair_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         rdy_q        <= 1'b1;
         pair_tdata_q <= pair_tdata_d;
         pair_cnt_q   <= pair_cnt_d;
      end
   end

   assign axis_pair_tvalid = (state_q == ST_PAIR);
   assign axis_pair_tdata  = pair_tdata_q;
   assign pair_count       = pair_cnt_q;

`ifdef META_PAIR_CHECK_EN
   logic           tuser_q, tuser_d;
   logic [MCW-1:0] mism_cnt_q, mism_cnt_d;
   logic [DW-1:0]  word2;

   assign word2 = acc2 ? axis_meta2_tdata : slot2_data;

   always_comb begin
      tuser_d    = tuser_q;
      mism_cnt_d = mism_cnt_q;
      if (enter_pair)
         tuser_d = (word1 != word2);
      if (hs && tuser_q && (mism_cnt_q != {MCW{1'b1}}))
         mism_cnt_d = mism_cnt_q + MCW'(1);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tuser_q    <= 1'b0;
         mism_cnt_q <= '0;
      end else begin
         tuser_q    <= tuser_d;
         mism_cnt_q <= mism_cnt_d;
      end
   end

   assign axis_pair_tuser = tuser_q;
   assign mismatch_count  = mism_cnt_q;
`else
   logic unused_slot2;
   assign unused_slot2    = ^slot2_data;
   assign axis_pair_tuser = 1'b0;
   assign mismatch_count  = '0;
`endif
endmodule

// File: tb/tb_meta_pair_rx.sv
// -----------------------------------------------------------------------------
// tb_meta_pair_rx
// Directed bench for meta_pair_rx (DW = 128, CW = 4 so counter wrap is short).
// Honours META_PAIR_CHECK_EN for tuser / mismatch_count expectations.
// -----------------------------------------------------------------------------
module tb_meta_pair_rx;
   localparam int DW = 128;
   localparam int CW = 4;
`ifdef META_PAIR_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          resetn;
   logic [DW-1:0] m1_data, m2_data;
   logic          m1_valid, m2_valid;
   logic          m1_ready, m2_ready;
   logic [DW-1:0] p_data;
   logic          p_valid, p_ready, p_user;
   logic [CW-1:0] p_cnt;
   logic [15:0]   m_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   meta_pair_rx #(.DW(DW), .CW(CW)) dut (
      .clk               (clk),
      .resetn            (resetn),
      .axis_meta1_tdata  (m1_data),
      .axis_meta1_tvalid (m1_valid),
      .axis_meta1_tready (m1_ready),
      .axis_meta2_tdata  (m2_data),
      .axis_meta2_tvalid (m2_valid),
      .axis_meta2_tready (m2_ready),
      .axis_pair_tdata   (p_data),
      .axis_pair_tvalid  (p_valid),
      .axis_pair_tready  (p_ready),
      .axis_pair_tuser   (p_user),
      .pair_count        (p_cnt),
      .mismatch_count    (m_cnt)
   );

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      resetn = 1'b0; m1_data = '0; m2_data = '0;
      m1_valid = 1'b0; m2_valid = 1'b0; p_ready = 1'b0;

      // ---- reset state (one clock edge passes while in reset)
      @(negedge clk);
      check("rst_tready1", m1_ready, 0);
      check("rst_tready2", m2_ready, 0);
      check("rst_tvalid",  p_valid,  0);
      check("rst_tdata",   p_data,   0);
      check("rst_tuser",   p_user,   0);
      check("rst_pcnt",    p_cnt,    0);
      check("rst_mcnt",    m_cnt,    0);
      resetn = 1'b1;
      #1;
      check("rel_tready1_pre", m1_ready, 0);
      @(negedge clk);
      check("rel_tready1", m1_ready, 1);
      check("rel_tready2", m2_ready, 1);
      $display("reset: tready=%0b/%0b tvalid=%0b", m1_ready, m2_ready, p_valid);

      // ---- continuous equal streams: one pair per 2 cycles
      m1_data = DW'(1638); m2_data = DW'(1638);
      m1_valid = 1'b1; m2_valid = 1'b1; p_ready = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         check($sformatf("cont_tvalid_%0d", k), p_valid, (k % 2 == 1) ? 1 : 0);
         check($sformatf("cont_tready1_%0d", k), m1_ready, (k % 2 == 1) ? 0 : 1);
         if (k % 2 == 1) begin
            check($sformatf("cont_tdata_%0d", k), p_data, 1638);
            check($sformatf("cont_tuser_%0d", k), p_user, 0);
         end
      end
      check("cont_pcnt", p_cnt, 10);
      $display("continuous: pair_count=%0d", p_cnt);

      // ---- stream 1 alone, stream 2 late by 7 cycles
      m2_valid = 1'b0;
      m1_data  = DW'(5);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         m1_valid = 1'b0;
         check($sformatf("late_tready1_%0d", k), m1_ready, 0);
         check($sformatf("late_tready2_%0d", k), m2_ready, 1);
         check($sformatf("late_tvalid_%0d", k),  p_valid,  0);
      end
      m2_valid = 1'b1; m2_data = DW'(5);
      @(negedge clk);
      m2_valid = 1'b0;
      check("late_pair_tvalid", p_valid, 1);
      check("late_pair_tdata",  p_data,  5);
      check("late_pair_tuser",  p_user,  0);
      @(negedge clk);
      check("late_done_tvalid", p_valid, 0);
      check("late_done_pcnt",   p_cnt,   11);
      $display("late stream2: pair_count=%0d", p_cnt);

      // ---- mismatch pair, then backpressure hold for 10 cycles
      m1_data = DW'(1638); m2_data = DW'(1639);
      m1_valid = 1'b1; m2_valid = 1'b1; p_ready = 1'b0;
      @(negedge clk);
      check("mis_tvalid", p_valid, 1);
      check("mis_tdata",  p_data,  1638);
      check("mis_tuser",  p_user,  CHK);
      m1_data = DW'(77); m2_data = DW'(78);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         check($sformatf("hold_tdata_%0d", k),   p_data,   1638);
         check($sformatf("hold_tuser_%0d", k),   p_user,   CHK);
         check($sformatf("hold_tvalid_%0d", k),  p_valid,  1);
         check($sformatf("hold_tready1_%0d", k), m1_ready, 0);
         check($sformatf("hold_tready2_%0d", k), m2_ready, 0);
         check($sformatf("hold_pcnt_%0d", k),    p_cnt,    11);
      end
      p_ready = 1'b1; m1_valid = 1'b0; m2_valid = 1'b0;
      @(negedge clk);
      check("mis_done_tvalid", p_valid, 0);
      check("mis_done_pcnt",   p_cnt,   12);
      check("mis_done_mcnt",   m_cnt,   CHK);
      $display("mismatch: pair_count=%0d mismatch_count=%0d", p_cnt, m_cnt);

      // ---- asynchronous reset while in GOT1
      m1_valid = 1'b1; m1_data = DW'(9);
      @(negedge clk);
      m1_valid = 1'b0;
      check("got1_tready1", m1_ready, 0);
      check("got1_tvalid",  p_valid,  0);
      #2 resetn = 1'b0;
      #1;
      check("arst_tready1", m1_ready, 0);
      check("arst_tready2", m2_ready, 0);
      check("arst_tvalid",  p_valid,  0);
      check("arst_tdata",   p_data,   0);
      check("arst_pcnt",    p_cnt,    0);
      check("arst_mcnt",    m_cnt,    0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      check("post_tready1", m1_ready, 1);
      check("post_tready2", m2_ready, 1);
      m2_valid = 1'b1; m2_data = DW'(3);
      @(negedge clk);
      m2_valid = 1'b0;
      check("post_got2_tvalid",  p_valid,  0);
      check("post_got2_tready2", m2_ready, 0);
      m1_valid = 1'b1; m1_data = DW'(3);
      @(negedge clk);
      m1_valid = 1'b0;
      check("post_pair_tvalid", p_valid, 1);
      check("post_pair_tdata",  p_data,  3);
      check("post_pair_tuser",  p_user,  0);
      @(negedge clk);
      check("post_pcnt", p_cnt, 1);
      $display("async reset: post-reset pair tdata=3 pair_count=%0d", p_cnt);

      // ---- pair_count wrap at 2^CW
      m1_data = DW'(1638); m2_data = DW'(1638);
      m1_valid = 1'b1; m2_valid = 1'b1;
      repeat (28) @(negedge clk);
      check("wrap_pcnt_max", p_cnt, 15);
      repeat (2) @(negedge clk);
      check("wrap_pcnt_zero", p_cnt, 0);
      m1_valid = 1'b0; m2_valid = 1'b0;
      $display("wrap: pair_count=%0d", p_cnt);

`ifdef META_PAIR_CHECK_EN
      // ---- mismatch counter saturation
      @(negedge clk);
      force dut.mism_cnt_q = 16'hFFFF;
      #1;
      release dut.mism_cnt_q;
      check("sat_pre_mcnt", m_cnt, 16'hFFFF);
      m1_data = DW'(1); m2_data = DW'(2);
      m1_valid = 1'b1; m2_valid = 1'b1;
      @(negedge clk);
      m1_valid = 1'b0; m2_valid = 1'b0;
      check("sat_tuser", p_user, 1);
      @(negedge clk);
      check("sat_mcnt", m_cnt, 16'hFFFF);
      check("sat_pcnt", p_cnt, 1);
      $display("saturation: mismatch_count=%0h", m_cnt);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
